// File: rtl/rv32_dmem_ctrl_if.sv
// Memory-stage request/response and data-bus signals of the RV32 data-memory controller.
// slave is the controller's view; master is the view of whoever drives the pipeline and the bus.
interface rv32_dmem_ctrl_if;
   logic        read_in;
   logic        write_in;
   logic [1:0]  width_in;
   logic        zero_extend_in;
   logic [31:0] address_in;
   logic [31:0] write_value_in;
   logic [31:0] read_value_out;
   logic        stall_out;
   logic        fault_out;
   logic [31:0] bus_address_out;
   logic        bus_read_out;
   logic        bus_write_out;
   logic [3:0]  bus_write_mask_out;
   logic [31:0] bus_write_value_out;
   logic [31:0] bus_read_value_in;
   logic        bus_ready_in;

   modport slave (
      input  read_in, write_in, width_in, zero_extend_in, address_in, write_value_in,
      input  bus_read_value_in, bus_ready_in,
      output read_value_out, stall_out, fault_out,
      output bus_address_out, bus_read_out, bus_write_out, bus_write_mask_out, bus_write_value_out
   );

   modport master (
      output read_in, write_in, width_in, zero_extend_in, address_in, write_value_in,
      output bus_read_value_in, bus_ready_in,
      input  read_value_out, stall_out, fault_out,
      input  bus_address_out, bus_read_out, bus_write_out, bus_write_mask_out, bus_write_value_out
   );
endinterface

// File: rtl/rv32_dmem_ctrl.sv
// RV32 data-memory controller: aligned loads/stores over a ready-handshaked bus, 2-cycle minimum latency.
// Stalls the pipeline until bus_ready_in; aborts with a fault after TIMEOUT_CYCLES waiting BUSY cycles.
module rv32_dmem_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   rv32_dmem_ctrl_if.slave bus
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  width_q, width_d;
   logic        zext_q, zext_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [3:0]  mask_q, mask_d;
   logic [31:0] wval_q, wval_d;

   logic        req;
   logic        misaligned;
   logic [1:0]  width_n;
   logic [3:0]  lane_mask;
   logic [31:0] lane_dat;
   logic [31:0] rd_shifted;
   logic [31:0] load_val;
   logic        stall;
   logic        fault;
   logic [31:0] read_val;

   // Width 3 is folded into word so every downstream decode sees only 0..2.
   always_comb begin
      req     = bus.read_in | bus.write_in;
      width_n = (bus.width_in == 2'd3) ? 2'd2 : bus.width_in;
      misaligned = ((width_n == 2'd1) && bus.address_in[0]) ||
                   ((width_n == 2'd2) && (bus.address_in[1:0] != 2'b00));
      lane_mask = 4'b1111;
      lane_dat  = bus.write_value_in;
      case (width_n)
         2'd0: begin
            lane_mask = 4'b0001 << bus.address_in[1:0];
            lane_dat  = {4{bus.write_value_in[7:0]}};
         end
         2'd1: begin
            lane_mask = bus.address_in[1] ? 4'b1100 : 4'b0011;
            lane_dat  = {2{bus.write_value_in[15:0]}};
         end
         default: begin
            lane_mask = 4'b1111;
            lane_dat  = bus.write_value_in;
         end
      endcase
   end

   // Halves are always 2-byte aligned here, so the byte shift also selects the half.
   always_comb begin
      rd_shifted = bus.bus_read_value_in >> {addr_q[1:0], 3'b000};
      case (width_q)
         2'd0:    load_val = zext_q ? {24'd0, rd_shifted[7:0]}
                                    : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
         2'd1:    load_val = zext_q ? {16'd0, rd_shifted[15:0]}
                                    : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
         default: load_val = bus.bus_read_value_in;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      width_d  = width_q;
      zext_d   = zext_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      mask_d   = mask_q;
      wval_d   = wval_q;
      stall    = 1'b0;
      fault    = 1'b0;
      read_val = 32'd0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (misaligned) begin
                  fault = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = BUSY;
                  cnt_d   = '0;
                  addr_d  = bus.address_in;
                  width_d = width_n;
                  zext_d  = bus.zero_extend_in;
                  rd_d    = bus.read_in;
                  wr_d    = ~bus.read_in;
                  mask_d  = bus.read_in ? 4'b0000 : lane_mask;
                  wval_d  = lane_dat;
               end
            end
         end
         BUSY: begin
            if (bus.bus_ready_in) begin
               read_val = rd_q ? load_val : 32'd0;
               state_d  = IDLE;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
            end else if (cnt_q == TMAX) begin
               fault   = 1'b1;
               state_d = IDLE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= 32'd0;
         width_q <= 2'd0;
         zext_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         mask_q  <= 4'd0;
         wval_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         width_q <= width_d;
         zext_q  <= zext_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         mask_q  <= mask_d;
         wval_q  <= wval_d;
      end
   end

   assign bus.read_value_out      = read_val;
   assign bus.stall_out           = stall;
   assign bus.fault_out           = fault;
   assign bus.bus_address_out     = {addr_q[31:2], 2'b00};
   assign bus.bus_read_out        = rd_q;
   assign bus.bus_write_out       = wr_q;
   assign bus.bus_write_mask_out  = mask_q;
   assign bus.bus_write_value_out = wval_q;

endmodule

// File: tb/tb_rv32_dmem_ctrl.sv
// Bench for rv32_dmem_ctrl: transaction-level reference model checked every cycle plus directed scenarios.
module tb_rv32_dmem_ctrl;
   localparam int unsigned TMO = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rv32_dmem_ctrl_if dif ();
   rv32_dmem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(dif));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] f_ext(input int w, input logic [31:0] a, input bit z,
                                         input logic [31:0] d);
      logic [31:0] v, lim;
      int bits;
      if (w == 2) return d;
      bits = (w == 0) ? 8 : 16;
      lim  = (32'd1 << bits) - 32'd1;
      v    = (d >> ((a % 4) * 8)) & lim;
      if (!z && v >= (lim + 32'd1) / 2) v = v | ~lim;
      return v;
   endfunction

   function automatic logic [31:0] f_lane(input int w, input logic [31:0] v);
      if (w == 0) return (v & 32'hFF) * 32'h01010101;
      if (w == 1) return (v & 32'hFFFF) * 32'h00010001;
      return v;
   endfunction

   function automatic logic [31:0] f_mask(input int w, input logic [31:0] a);
      if (w == 0) return 32'd1 << (a % 4);
      if (w == 1) return 32'd3 << (a & 32'd2);
      return 32'hF;
   endfunction

   // Reference model: one pending access record, advanced at each negedge.
   bit          m_known = 0;
   bit          m_busy  = 0;
   bit          m_rd, m_zext, m_req, m_mis, m_tmo;
   int          m_width, m_cnt, m_w;
   logic [31:0] m_addr, m_wval;

   always @(negedge clk) begin
      m_req = dif.read_in || dif.write_in;
      m_w   = (dif.width_in == 2'd3) ? 2 : int'(dif.width_in);
      m_mis = (m_w == 1 && dif.address_in % 2 != 0) || (m_w == 2 && dif.address_in % 4 != 0);
      m_tmo = m_busy && (m_cnt == TMO) && !dif.bus_ready_in;
      if (m_known) begin
         if (!m_busy) begin
            chk("idle_stall", dif.stall_out, m_req && !m_mis);
            chk("idle_fault", dif.fault_out, m_req && m_mis);
            chk("idle_rdata", dif.read_value_out, 32'd0);
            chk("idle_bus_rd", dif.bus_read_out, 0);
            chk("idle_bus_wr", dif.bus_write_out, 0);
         end else begin
            chk("busy_stall", dif.stall_out, !dif.bus_ready_in && !m_tmo);
            chk("busy_fault", dif.fault_out, m_tmo);
            chk("busy_rdata", dif.read_value_out,
                (dif.bus_ready_in && m_rd) ? f_ext(m_width, m_addr, m_zext, dif.bus_read_value_in) : 32'd0);
            chk("busy_bus_rd", dif.bus_read_out, m_rd);
            chk("busy_bus_wr", dif.bus_write_out, !m_rd);
            chk("busy_addr", dif.bus_address_out, m_addr & ~32'd3);
            if (!m_rd) begin
               chk("busy_mask", dif.bus_write_mask_out, f_mask(m_width, m_addr));
               chk("busy_wval", dif.bus_write_value_out, f_lane(m_width, m_wval));
            end
         end
      end
      if (reset) begin
         m_known = 1;
         m_busy  = 0;
      end else if (m_known) begin
         if (!m_busy) begin
            if (m_req && !m_mis) begin
               m_busy  = 1;
               m_rd    = dif.read_in;
               m_addr  = dif.address_in;
               m_width = m_w;
               m_zext  = dif.zero_extend_in;
               m_wval  = dif.write_value_in;
               m_cnt   = 0;
            end
         end else if (dif.bus_ready_in || m_tmo) begin
            m_busy = 0;
         end else if (m_cnt < TMO) begin
            m_cnt++;
         end
      end
   end

   task automatic drive(input bit rd, input bit wr, input logic [1:0] w, input bit z,
                        input logic [31:0] a, input logic [31:0] v, input bit rdy,
                        input logic [31:0] rdat);
      dif.read_in           = rd;
      dif.write_in          = wr;
      dif.width_in          = w;
      dif.zero_extend_in    = z;
      dif.address_in        = a;
      dif.write_value_in    = v;
      dif.bus_ready_in      = rdy;
      dif.bus_read_value_in = rdat;
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rdy);
      drive(0, 0, 2'd0, 0, 32'd0, 32'd0, rdy, 32'd0);
   endtask

   int stall_cnt;

   initial begin
      idle(0);
      nxt;
      nxt;
      reset = 1'b0;
      #2;
      chk("rst_addr", dif.bus_address_out, 32'd0);
      chk("rst_mask", dif.bus_write_mask_out, 32'd0);
      chk("rst_wval", dif.bus_write_value_out, 32'd0);
      chk("rst_rd", dif.bus_read_out, 0);
      chk("rst_wr", dif.bus_write_out, 0);
      chk("rst_stall", dif.stall_out, 0);
      chk("rst_fault", dif.fault_out, 0);

      // Word load at 0x100, ready in the first BUSY cycle.
      nxt; drive(1, 0, 2'd2, 0, 32'h100, 32'd0, 0, 32'd0); #2;
      chk("wl_issue_stall", dif.stall_out, 1);
      nxt; drive(0, 0, 2'd0, 0, 32'd0, 32'd0, 1, 32'hDEADBEEF); #2;
      chk("wl_done_stall", dif.stall_out, 0);
      chk("wl_rdata", dif.read_value_out, 32'hDEADBEEF);
      chk("wl_addr", dif.bus_address_out, 32'h100);
      chk("wl_strobe", dif.bus_read_out, 1);

      // Byte loads at 0x103, sign- then zero-extended, issued back to back.
      nxt; drive(1, 0, 2'd0, 0, 32'h103, 32'd0, 0, 32'd0); #2;
      chk("wl_after_rd", dif.bus_read_out, 0);
      nxt; drive(0, 0, 2'd0, 0, 32'd0, 32'd0, 1, 32'h80112233); #2;
      chk("bl_sext", dif.read_value_out, 32'hFFFFFF80);
      nxt; drive(1, 0, 2'd0, 1, 32'h103, 32'd0, 0, 32'd0); #2;
      chk("bl_nobubble", dif.stall_out, 1);
      nxt; drive(0, 0, 2'd0, 0, 32'd0, 32'd0, 1, 32'h80112233); #2;
      chk("bl_zext", dif.read_value_out, 32'h00000080);

      // Half store of 0xABCD at 0x202, ready after 3 waiting BUSY cycles.
      nxt; drive(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 0, 32'd0); #2;
      stall_cnt = dif.stall_out ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         nxt; idle(0); #2;
         chk("hs_mask", dif.bus_write_mask_out, 32'hC);
         chk("hs_wval", dif.bus_write_value_out, 32'hABCDABCD);
         chk("hs_strobe", dif.bus_write_out, 1);
         if (dif.stall_out) stall_cnt++;
      end
      nxt; idle(1); #2;
      chk("hs_done_stall", dif.stall_out, 0);
      chk("hs_done_wval", dif.bus_write_value_out, 32'hABCDABCD);
      chk("hs_stall_cycles", stall_cnt, 4);

      // Misaligned word load.
      nxt; drive(1, 0, 2'd2, 0, 32'h101, 32'd0, 0, 32'd0); #2;
      chk("mis_fault", dif.fault_out, 1);
      chk("mis_stall", dif.stall_out, 0);
      nxt; idle(0); #2;
      chk("mis_no_rd", dif.bus_read_out, 0);
      chk("mis_no_wr", dif.bus_write_out, 0);

      // Timeout with ready held low.
      nxt; drive(1, 0, 2'd2, 0, 32'h40, 32'd0, 0, 32'd0); #2;
      chk("to_issue_stall", dif.stall_out, 1);
      for (int i = 0; i < 4; i++) begin
         nxt; idle(0); #2;
         chk("to_wait_fault", dif.fault_out, 0);
         chk("to_wait_stall", dif.stall_out, 1);
      end
      nxt; idle(0); #2;
      chk("to_fault", dif.fault_out, 1);
      chk("to_stall", dif.stall_out, 0);
      nxt; idle(0); #2;
      chk("to_after_fault", dif.fault_out, 0);
      chk("to_after_rd", dif.bus_read_out, 0);

      // Reset in the second BUSY cycle of a store.
      nxt; drive(0, 1, 2'd2, 0, 32'h300, 32'h12345678, 0, 32'd0);
      nxt; idle(0);
      nxt; reset = 1'b1; #2;
      chk("rb_strobe_before", dif.bus_write_out, 1);
      nxt; reset = 1'b0; drive(1, 0, 2'd2, 0, 32'h400, 32'd0, 0, 32'd0); #2;
      chk("rb_wr_cleared", dif.bus_write_out, 0);
      chk("rb_rd_cleared", dif.bus_read_out, 0);
      chk("rb_idle_issue", dif.stall_out, 1);
      nxt; idle(1); #2;
      chk("rb_new_rd", dif.bus_read_out, 1);
      chk("rb_new_addr", dif.bus_address_out, 32'h400);

      // Randomized traffic, including timeouts and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         logic [1:0] op;
         nxt;
         reset = ($urandom_range(0, 99) == 0);
         op = 2'($urandom_range(0, 3));
         drive(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
               $urandom, ($urandom_range(0, 2) == 0), $urandom);
      end
      nxt; reset = 1'b0; idle(0);
      nxt; nxt;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
